// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and hazard controller for the 5-stage pipeline.
// Keeps shadow copies of the destination info held by the EXE and MEM stages,
// registers the EXE forwarding-mux selects one cycle after ID sampling, and
// raises a combinational stall for load-use (or any RAW hazard when
// forwarding is disabled).
//
// Ports:
//   clk, rst                 pipeline clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_src1, id_src2         source registers (src2 also carries store data)
//   id_use_src1/2            ALU operands read src1/src2 (src2=0 -> immediate)
//   id_is_store              store instruction, data from src2
//   id_dest, id_wb_en        destination register and write-back enable
//   id_mem_read              instruction is a load
//   fwd_en                   forwarding enabled (0 = stall-only mode)
//   flush                    discard the ID instruction
//   val1_sel, val2_sel       EXE operand selects (00 RF, 01 ALU_res_MEM, 10 result_WB)
//   ST_val_sel               EXE store-value select
//   stall                    freeze PC and IF/ID, bubble into EXE (combinational)
//   stall_count              saturating count of stall cycles
module fwd_hazard_ctrl #(
   parameter int unsigned REG_ADDR_LEN = 5,
   parameter int unsigned FORW_SEL_LEN = 2,
   parameter int unsigned CNT_LEN      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [REG_ADDR_LEN-1:0] id_src1,
   input  logic [REG_ADDR_LEN-1:0] id_src2,
   input  logic                    id_use_src1,
   input  logic                    id_use_src2,
   input  logic                    id_is_store,
   input  logic [REG_ADDR_LEN-1:0] id_dest,
   input  logic                    id_wb_en,
   input  logic                    id_mem_read,
   input  logic                    fwd_en,
   input  logic                    flush,
   output logic [FORW_SEL_LEN-1:0] val1_sel,
   output logic [FORW_SEL_LEN-1:0] val2_sel,
   output logic [FORW_SEL_LEN-1:0] ST_val_sel,
   output logic                    stall,
   output logic [CNT_LEN-1:0]      stall_count
);

   localparam logic [FORW_SEL_LEN-1:0] SEL_RF  = FORW_SEL_LEN'(0);
   localparam logic [FORW_SEL_LEN-1:0] SEL_MEM = FORW_SEL_LEN'(1);
   localparam logic [FORW_SEL_LEN-1:0] SEL_WB  = FORW_SEL_LEN'(2);

   // Shadow EXE stage
   logic                    ex_valid;
   logic [REG_ADDR_LEN-1:0] ex_dest;
   logic                    ex_wb_en;
   logic                    ex_mem_read;

   // Shadow MEM stage
   logic                    mem_valid;
   logic [REG_ADDR_LEN-1:0] mem_dest;
   logic                    mem_wb_en;

   logic need1, need2;
   logic ex_m1, ex_m2, mem_m1, mem_m2;
   logic hazard, accept;
   logic [FORW_SEL_LEN-1:0] val1_nxt, val2_nxt, st_nxt;

   // A stage matches r when it will write r; r0 is hard-wired and never matches.
   function automatic logic stage_match(input logic v, input logic wb,
                                        input logic [REG_ADDR_LEN-1:0] dest,
                                        input logic [REG_ADDR_LEN-1:0] r);
      return v & wb & (dest == r) & (r != '0);
   endfunction

   // Youngest producer wins: EXE result (now in MEM) before the WB result.
   function automatic logic [FORW_SEL_LEN-1:0] pick(input logic use_r,
                                                    input logic ex_m,
                                                    input logic mem_m);
      if (!use_r) return SEL_RF;
      if (ex_m)   return SEL_MEM;
      if (mem_m)  return SEL_WB;
      return SEL_RF;
   endfunction

   assign need1  = id_use_src1;
   assign need2  = id_use_src2 | id_is_store;
   assign ex_m1  = stage_match(ex_valid,  ex_wb_en,  ex_dest,  id_src1);
   assign ex_m2  = stage_match(ex_valid,  ex_wb_en,  ex_dest,  id_src2);
   assign mem_m1 = stage_match(mem_valid, mem_wb_en, mem_dest, id_src1);
   assign mem_m2 = stage_match(mem_valid, mem_wb_en, mem_dest, id_src2);

   // Hazard detection: load-use only when forwarding, any EX/MEM RAW otherwise.
   always_comb begin
      hazard = 1'b0;
      if (fwd_en) begin
         hazard = ex_mem_read & ((need1 & ex_m1) | (need2 & ex_m2));
      end else begin
         hazard = (need1 & (ex_m1 | mem_m1)) | (need2 & (ex_m2 | mem_m2));
      end
   end

   assign stall  = id_valid & ~flush & hazard;
   assign accept = id_valid & ~flush & ~hazard;

   // Next-cycle selects; anything not accepted or in stall-only mode reads the RF.
   always_comb begin
      val1_nxt = SEL_RF;
      val2_nxt = SEL_RF;
      st_nxt   = SEL_RF;
      if (accept && fwd_en) begin
         val1_nxt = pick(id_use_src1, ex_m1, mem_m1);
         val2_nxt = pick(id_use_src2, ex_m2, mem_m2);
         st_nxt   = pick(id_is_store, ex_m2, mem_m2);
      end
   end

   // Shadow pipeline, registered selects and stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_dest     <= '0;
         ex_wb_en    <= 1'b0;
         ex_mem_read <= 1'b0;
         mem_valid   <= 1'b0;
         mem_dest    <= '0;
         mem_wb_en   <= 1'b0;
         val1_sel    <= SEL_RF;
         val2_sel    <= SEL_RF;
         ST_val_sel  <= SEL_RF;
         stall_count <= '0;
      end else begin
         mem_valid <= ex_valid;
         mem_dest  <= ex_dest;
         mem_wb_en <= ex_wb_en;
         if (accept) begin
            ex_valid    <= 1'b1;
            ex_dest     <= id_dest;
            ex_wb_en    <= id_wb_en;
            ex_mem_read <= id_mem_read;
         end else begin
            ex_valid    <= 1'b0;
            ex_dest     <= '0;
            ex_wb_en    <= 1'b0;
            ex_mem_read <= 1'b0;
         end
         val1_sel   <= val1_nxt;
         val2_sel   <= val2_nxt;
         ST_val_sel <= st_nxt;
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_LEN'(1);
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second instance with an 8-bit stall
// counter shares all stimulus so saturation is reachable in a short run.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_src1, id_src2, id_dest;
   logic       id_use_src1, id_use_src2, id_is_store, id_wb_en, id_mem_read;
   logic       fwd_en, flush;
   logic [1:0] val1_sel, val2_sel, ST_val_sel;
   logic       stall;
   logic [15:0] stall_count;
   logic [1:0] s_val1_sel, s_val2_sel, s_st_sel;
   logic       s_stall;
   logic [7:0] s_stall_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_is_store(id_is_store),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .fwd_en(fwd_en), .flush(flush), .val1_sel(val1_sel), .val2_sel(val2_sel),
      .ST_val_sel(ST_val_sel), .stall(stall), .stall_count(stall_count));

   fwd_hazard_ctrl #(.CNT_LEN(8)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_is_store(id_is_store),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .fwd_en(fwd_en), .flush(flush), .val1_sel(s_val1_sel), .val2_sel(s_val2_sel),
      .ST_val_sel(s_st_sel), .stall(s_stall), .stall_count(s_stall_count));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2, input logic st,
                         input logic [4:0] d, input logic wb, input logic mr);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
      id_is_store = st; id_dest = d; id_wb_en = wb; id_mem_read = mr;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic clear_pipe();
      idle();
      tick();
      tick();
   endtask

   task automatic test_reset();
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL reset_val1 got=%b exp=00", val1_sel); end
      checks++; if (val2_sel !== 2'b00) begin failures++; $display("FAIL reset_val2 got=%b exp=00", val2_sel); end
      checks++; if (ST_val_sel !== 2'b00) begin failures++; $display("FAIL reset_st got=%b exp=00", ST_val_sel); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
   endtask

   task automatic test_raw();
      // ADD r3 ; SUB r5 = r3 - r4 -> EX forward on operand 1
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 0, 5'd5, 1, 0);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_no_stall got=%b exp=0", stall); end
      tick();
      checks++; if (val1_sel !== 2'b01) begin failures++; $display("FAIL raw_ex_val1 got=%b exp=01", val1_sel); end
      checks++; if (val2_sel !== 2'b00) begin failures++; $display("FAIL raw_ex_val2 got=%b exp=00", val2_sel); end
      // one NOP between -> WB forward
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
      idle(); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 0, 5'd5, 1, 0); tick();
      checks++; if (val1_sel !== 2'b10) begin failures++; $display("FAIL raw_mem_val1 got=%b exp=10", val1_sel); end
      checks++; if (val2_sel !== 2'b00) begin failures++; $display("FAIL raw_mem_val2 got=%b exp=00", val2_sel); end
      // destination r0 never forwards
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0); tick();
      set_id(1, 5'd0, 5'd4, 1, 1, 0, 5'd5, 1, 0); tick();
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL raw_r0_val1 got=%b exp=00", val1_sel); end
   endtask

   task automatic test_load_use();
      clear_pipe();
      set_id(1, 5'd1, 5'd0, 1, 0, 0, 5'd2, 1, 1); tick();      // LW r2
      set_id(1, 5'd2, 5'd2, 1, 1, 0, 5'd6, 1, 0);              // ADD r6 = r2 + r2
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
      tick();
      checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL lu_bubble_val1 got=%b exp=00", val1_sel); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", stall); end
      tick();
      checks++; if (val1_sel !== 2'b10) begin failures++; $display("FAIL lu_val1 got=%b exp=10", val1_sel); end
      checks++; if (val2_sel !== 2'b10) begin failures++; $display("FAIL lu_val2 got=%b exp=10", val2_sel); end
      checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count_hold got=%0d exp=1", stall_count); end
   endtask

   task automatic test_store();
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd7, 1, 0); tick();      // ADD r7
      set_id(1, 5'd1, 5'd7, 1, 0, 1, 5'd0, 0, 0); tick();      // SW r7, imm(r1)
      checks++; if (ST_val_sel !== 2'b01) begin failures++; $display("FAIL st_ex got=%b exp=01", ST_val_sel); end
      checks++; if (val2_sel !== 2'b00) begin failures++; $display("FAIL st_val2 got=%b exp=00", val2_sel); end
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL st_val1 got=%b exp=00", val1_sel); end
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd7, 1, 0); tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd7, 1, 0); tick();
      set_id(1, 5'd1, 5'd7, 1, 0, 1, 5'd0, 0, 0); tick();
      checks++; if (ST_val_sel !== 2'b01) begin failures++; $display("FAIL st_priority got=%b exp=01", ST_val_sel); end
   endtask

   task automatic test_no_fwd();
      clear_pipe();
      fwd_en = 1'b0;
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 0, 5'd5, 1, 0);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL nf_stall1 got=%b exp=1", stall); end
      tick();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL nf_stall2 got=%b exp=1", stall); end
      tick();
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nf_release got=%b exp=0", stall); end
      checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL nf_count got=%0d exp=3", stall_count); end
      tick();
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL nf_val1 got=%b exp=00", val1_sel); end
      // flush beats stall
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 0, 5'd5, 1, 0);
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
      tick();
      flush = 1'b0;
      checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL flush_count got=%0d exp=3", stall_count); end
      fwd_en = 1'b1;
   endtask

   task automatic test_async_reset();
      clear_pipe();
      set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 0, 5'd5, 1, 0); tick();
      idle();
      checks++; if (val1_sel !== 2'b01) begin failures++; $display("FAIL ar_pre_val1 got=%b exp=01", val1_sel); end
      #2 rst = 1'b1;
      #1;
      checks++; if (val1_sel !== 2'b00) begin failures++; $display("FAIL ar_val1 got=%b exp=00", val1_sel); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", stall_count); end
      #2 rst = 1'b0;
   endtask

   task automatic test_saturation();
      clear_pipe();
      // LW r2, 0(r2) repeated: stalls on every second edge
      set_id(1, 5'd2, 5'd0, 1, 0, 0, 5'd2, 1, 1);
      repeat (200) tick();
      checks++; if (stall_count !== 16'd100) begin failures++; $display("FAIL sat_mid got=%0d exp=100", stall_count); end
      checks++; if (s_stall_count !== 8'd100) begin failures++; $display("FAIL sat8_mid got=%0d exp=100", s_stall_count); end
      repeat (400) tick();
      idle(); tick();
      checks++; if (stall_count !== 16'd300) begin failures++; $display("FAIL sat_wide got=%0d exp=300", stall_count); end
      checks++; if (s_stall_count !== 8'd255) begin failures++; $display("FAIL sat8_hold got=%0d exp=255", s_stall_count); end
   endtask

   initial begin
      rst = 1'b1;
      fwd_en = 1'b1;
      flush = 1'b0;
      idle();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_raw();
      test_load_use();
      test_store();
      test_no_fwd();
      test_async_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks destination-register info of in-flight instructions in internal EXE and MEM shadow stages.
- Produces registered mux selects (val1_sel, val2_sel, ST_val_sel) for the EXE-stage forwarding muxes, plus a load-use stall for the front end.
- Sits beside the ID/EXE pipeline register; samples decoded ID fields every cycle.

Parameters:
- REG_ADDR_LEN, 5, register-number width.
- FORW_SEL_LEN, 2, forwarding select width.
- CNT_LEN, 16, stall-counter width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- id_valid  input  1  ID holds a real instruction
- id_src1  input  REG_ADDR_LEN  first source register
- id_src2  input  REG_ADDR_LEN  second source register (also the store-data register)
- id_use_src1  input  1  ALU operand 1 reads src1
- id_use_src2  input  1  ALU operand 2 reads src2 (0 = immediate)
- id_is_store  input  1  instruction is a store; store data comes from src2
- id_dest  input  REG_ADDR_LEN  destination register
- id_wb_en  input  1  instruction writes back
- id_mem_read  input  1  instruction is a load
- fwd_en  input  1  forwarding enabled; 0 = stall-only mode
- flush  input  1  discard the ID instruction (taken branch)
- val1_sel  output  FORW_SEL_LEN  EXE operand-1 select
- val2_sel  output  FORW_SEL_LEN  EXE operand-2 select
- ST_val_sel  output  FORW_SEL_LEN  EXE store-value select
- stall  output  1  freeze PC and IF/ID; bubble into EXE
- stall_count  output  CNT_LEN  saturating count of stall cycles

Behaviour:
- Select encoding: 00 = register-file value, 01 = ALU_res_MEM, 10 = result_WB. 11 is never driven.
- Shadow stages:
  - EX: ex_valid, ex_dest, ex_wb_en, ex_mem_read.
  - MEM: mem_valid, mem_dest, mem_wb_en.
- Reset: all shadow state 0; val1_sel, val2_sel, ST_val_sel = 00; stall_count = 0. stall reads 0 because shadow state is clear.
- Match definition: EX match(r) = ex_valid & ex_wb_en & (ex_dest == r) & (r != 0). MEM match(r) is defined the same way from the MEM stage. Register 0 never matches.
- Need flags:
  - src1 needed if id_use_src1.
  - src2 needed if id_use_src2 or id_is_store.
- stall (combinational) = id_valid & !flush & (hazard):
  - fwd_en=1: hazard = a needed source EX-matches and ex_mem_read=1 (load-use).
  - fwd_en=0: hazard = a needed source EX-matches or MEM-matches. The register file is write-before-read, so WB needs no stall.
- Per-clock update:
  - MEM <= EX.
  - If (!id_valid | flush | stall): EX <= bubble (valid 0) and all selects <= 00.
  - Else EX <= ID fields and selects are registered as follows.
- Select computation for an accepted instruction, with fwd_en=1:
  - val1_sel = 01 if id_use_src1 & EX-match(src1); else 10 if id_use_src1 & MEM-match(src1); else 00.
  - val2_sel: same rule on src2, gated by id_use_src2.
  - ST_val_sel: same rule on src2, gated by id_is_store.
  - EX priority over MEM (youngest wins).
- With fwd_en=0, all selects register 00.
- Latency: selects are valid during exactly the cycle the instruction occupies EXE (one cycle after ID sampling).
- After a load-use stall, the load advances to MEM. The re-evaluated instruction then sees a MEM match and gets select 10 (one stall cycle total).
- stall_count increments on each cycle stall=1 and saturates at all-ones. Cleared only by rst.
- flush and stall together: flush wins; stall=0, bubble inserted, no count.
- rst asserted mid-operation clears all state immediately (asynchronous).

Test Plan:
- Reset, then idle: selects 00, stall 0, stall_count 0. Asserting rst mid-stream zeroes the outputs without waiting for a clock edge.
- ADD r3 (dest r3), then SUB r5 = r3 - r4: SUB's EXE cycle has val1_sel=01, val2_sel=00. With one NOP between them: val1_sel=10. With dest r0 instead of r3: 00.
- LW r2, then ADD r6 = r2 + r2: stall=1 for one cycle, stall_count=1, bubble in EXE. ADD's EXE cycle then has val1_sel=val2_sel=10.
- ADD r7, then SW stores r7 with immediate offset (use_src2=0, is_store=1): ST_val_sel=01, val2_sel=00. ADD r7, ADD r7, then SW r7: EX priority gives ST_val_sel=01.
- fwd_en=0, ADD r3 then SUB uses r3: stall=1 for 2 cycles, stall_count=2, then selects 00. Same with flush=1 on SUB: stall=0, no count.
- Force 70000 consecutive load-use stalls: stall_count holds at 65535.
